rx_clk_div_reset: RTL and testbench

Receive-side counterpart of the GTX transmit clock-divider reset sequencer: after RX PLL lock, it runs the GTXTEST[1] double-pulse sequence required when the RX serial clock divider is in use. It then resets the RX CDR and the RX elastic buffer, and flags completion to the link bring-up logic. It sits beside the GTX wrapper, one instance per receive lane, in the 40 MHz fabric clock domain.

---
 rtl/rx_clk_div_reset.sv | 110 +++++++++++
 tb/tb_rx_clk_div_reset.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rx_clk_div_reset.sv
// RX clock-divider reset sequencer: GTXTEST[1] double pulse after lock, then CDR and buffer resets.
// Optional macro RX_BUF_RST_EN keeps the RXBUFRESET stage; without it CDR_RST goes straight to DONE.
module rx_clk_div_reset #(
  parameter int unsigned LOCK_WAIT   = 1024,
  parameter int unsigned PULSE_LEN   = 256,
  parameter int unsigned GAP_LEN     = 256,
  parameter int unsigned CDR_RST_LEN = 16,
  parameter int unsigned BUF_RST_LEN = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic PLLLKDET,
  input  logic RX_RATE,
  input  logic ENA,
  output logic GTXTEST_BIT1,
  output logic RXCDRRESET,
  output logic RXBUFRESET,
  output logic RX_DIV_DONE
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOCK_WAIT = 3'd1;
  localparam logic [2:0] S_PULSE1    = 3'd2;
  localparam logic [2:0] S_GAP       = 3'd3;
  localparam logic [2:0] S_PULSE2    = 3'd4;
  localparam logic [2:0] S_CDR_RST   = 3'd5;
  localparam logic [2:0] S_BUF_RST   = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

`ifdef RX_BUF_RST_EN
  localparam logic [2:0] S_AFTER_CDR = S_BUF_RST;
`else
  localparam logic [2:0] S_AFTER_CDR = S_DONE;
`endif

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [11:0] cnt;
  logic [11:0] state_len;
  logic        last_cycle;
  logic        rate_q;
  logic        abort;

  // Length of the current timed state; untimed states never reach their limit.
  always_comb begin
    state_len = 12'hFFF;
    case (state)
      S_LOCK_WAIT: state_len = 12'(LOCK_WAIT);
      S_PULSE1:    state_len = 12'(PULSE_LEN);
      S_GAP:       state_len = 12'(GAP_LEN);
      S_PULSE2:    state_len = 12'(PULSE_LEN);
      S_CDR_RST:   state_len = 12'(CDR_RST_LEN);
      S_BUF_RST:   state_len = 12'(BUF_RST_LEN);
      default:     state_len = 12'hFFF;
    endcase
  end

  assign last_cycle = (cnt == (state_len - 12'd1));

  // Any abort (enable, lock, or rate change) wins over a timed exit.
  assign abort = (state != S_IDLE) && (!ENA || !PLLLKDET || (RX_RATE != rate_q));

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (ENA && PLLLKDET) state_nxt = S_LOCK_WAIT;
        S_LOCK_WAIT: if (last_cycle) state_nxt = rate_q ? S_PULSE1 : S_CDR_RST;
        S_PULSE1:    if (last_cycle) state_nxt = S_GAP;
        S_GAP:       if (last_cycle) state_nxt = S_PULSE2;
        S_PULSE2:    if (last_cycle) state_nxt = S_CDR_RST;
        S_CDR_RST:   if (last_cycle) state_nxt = S_AFTER_CDR;
        S_BUF_RST:   if (last_cycle) state_nxt = S_DONE;
        S_DONE:      state_nxt = S_DONE;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state occupancy.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rate_q       <= 1'b0;
      GTXTEST_BIT1 <= 1'b0;
      RXCDRRESET   <= 1'b0;
      RX_DIV_DONE  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= (state_nxt != state) ? 12'd0 : cnt + 12'd1;
      if (state == S_IDLE && state_nxt == S_LOCK_WAIT) rate_q <= RX_RATE;
      GTXTEST_BIT1 <= (state_nxt == S_PULSE1) || (state_nxt == S_PULSE2);
      RXCDRRESET   <= (state_nxt == S_CDR_RST);
      RX_DIV_DONE  <= (state_nxt == S_DONE);
    end
  end

`ifdef RX_BUF_RST_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) RXBUFRESET <= 1'b0;
    else        RXBUFRESET <= (state_nxt == S_BUF_RST);
  end
`else
  assign RXBUFRESET = 1'b0;
`endif

endmodule

// File: tb/tb_rx_clk_div_reset.sv
// Bench for rx_clk_div_reset: directed scenarios plus random input upsets,
// checked every cycle against a schedule model built from the sequence timings.
module tb_rx_clk_div_reset;

  localparam int LW = 1024;
  localparam int PL = 256;
  localparam int GP = 256;
  localparam int CR = 16;
  localparam int BR = 16;

`ifdef RX_BUF_RST_EN
  localparam int DONE_R1 = 1825;
  localparam int DONE_R0 = 1057;
  localparam int BUF_R1  = 1809;
`else
  localparam int DONE_R1 = 1809;
  localparam int DONE_R0 = 1041;
  localparam int BUF_R1  = -1;
`endif

  logic CLK = 1'b0;
  logic RST_N, PLLLKDET, RX_RATE, ENA;
  logic GTXTEST_BIT1, RXCDRRESET, RXBUFRESET, RX_DIV_DONE;

  int vectors = 0;
  int miscompares = 0;
  int edge_no = 0;

  bit m_idle = 1'b1;
  int m_start = 0;
  bit m_rate = 1'b0;
  int first_gtx = -1, first_cdr = -1, first_buf = -1, first_done = -1;

  always #5 CLK = ~CLK;

  rx_clk_div_reset dut (
    .CLK(CLK), .RST_N(RST_N), .PLLLKDET(PLLLKDET), .RX_RATE(RX_RATE), .ENA(ENA),
    .GTXTEST_BIT1(GTXTEST_BIT1), .RXCDRRESET(RXCDRRESET),
    .RXBUFRESET(RXBUFRESET), .RX_DIV_DONE(RX_DIV_DONE)
  );

  // Expected {gtx, cdr, buf, done} for cycle t counted from the start edge.
  function automatic logic [3:0] expected_out(int t, bit rate);
    int bound = LW;
    if (t <= bound) return 4'b0000;
    if (rate) begin
      if (t <= bound + PL) return 4'b1000;
      bound += PL;
      if (t <= bound + GP) return 4'b0000;
      bound += GP;
      if (t <= bound + PL) return 4'b1000;
      bound += PL;
    end
    if (t <= bound + CR) return 4'b0100;
    bound += CR;
`ifdef RX_BUF_RST_EN
    if (t <= bound + BR) return 4'b0010;
    bound += BR;
`endif
    return 4'b0001;
  endfunction

  task automatic checkOutput();
    logic [3:0] obs, exp;
    int t;
    obs = {GTXTEST_BIT1, RXCDRRESET, RXBUFRESET, RX_DIV_DONE};
    t = edge_no + 1 - m_start;
    exp = m_idle ? 4'b0000 : expected_out(t, m_rate);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL outputs edge=%0d t=%0d observed=%b expected=%b", edge_no, t, obs, exp);
    end
    if (!m_idle) begin
      if (obs[3] === 1'b1 && first_gtx < 0)  first_gtx  = t;
      if (obs[2] === 1'b1 && first_cdr < 0)  first_cdr  = t;
      if (obs[1] === 1'b1 && first_buf < 0)  first_buf  = t;
      if (obs[0] === 1'b1 && first_done < 0) first_done = t;
    end
  endtask

  task automatic checkAnchor(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst_n, input bit ena, input bit lk, input bit rate, input int n);
    for (int i = 0; i < n; i++) begin
      RST_N = rst_n; ENA = ena; PLLLKDET = lk; RX_RATE = rate;
      @(posedge CLK);
      edge_no++;
      if (!rst_n) begin
        m_idle = 1'b1;
      end else if (m_idle) begin
        if (ena && lk) begin
          m_idle = 1'b0; m_start = edge_no; m_rate = rate;
          first_gtx = -1; first_cdr = -1; first_buf = -1; first_done = -1;
        end
      end else if (!ena || !lk || (rate != m_rate)) begin
        m_idle = 1'b1;
      end
      #1;
      checkOutput();
    end
  endtask

  initial begin
    bit r, e, l, rt;
    RST_N = 1'b0; ENA = 1'b0; PLLLKDET = 1'b0; RX_RATE = 1'b0;
    $display("[TB] reset");
    applyStimulus(0, 0, 0, 0, 2);

    $display("[TB] full sequence, rate=1");
    applyStimulus(1, 1, 1, 1, 1900);
    checkAnchor("r1_gtx_first", first_gtx, 1025);
    checkAnchor("r1_cdr_first", first_cdr, 1793);
    checkAnchor("r1_buf_first", first_buf, BUF_R1);
    checkAnchor("r1_done_first", first_done, DONE_R1);

    $display("[TB] rate toggle in DONE, rerun at rate=0");
    applyStimulus(1, 1, 1, 0, 1100);
    checkAnchor("r0_gtx_first", first_gtx, -1);
    checkAnchor("r0_cdr_first", first_cdr, 1025);
    checkAnchor("r0_done_first", first_done, DONE_R0);

    $display("[TB] lock loss inside PULSE1, relock");
    applyStimulus(1, 0, 1, 1, 2);
    applyStimulus(1, 1, 1, 1, 1);
    applyStimulus(1, 1, 1, 1, 1099);
    applyStimulus(1, 1, 0, 1, 100);
    applyStimulus(1, 1, 1, 1, 1900);
    checkAnchor("relock_gtx_first", first_gtx, 1025);
    checkAnchor("relock_done_first", first_done, DONE_R1);

    $display("[TB] reset pulse during GAP");
    applyStimulus(1, 0, 1, 1, 2);
    applyStimulus(1, 1, 1, 1, 1);
    applyStimulus(1, 1, 1, 1, 1399);
    applyStimulus(0, 1, 1, 1, 1);
    applyStimulus(1, 0, 1, 1, 5);
    applyStimulus(1, 1, 1, 1, 1900);
    checkAnchor("rst_gtx_first", first_gtx, 1025);
    checkAnchor("rst_done_first", first_done, DONE_R1);

    $display("[TB] random upsets");
    e = 1'b1; l = 1'b1; rt = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      r = ($urandom_range(0, 4999) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 2999) == 0) e  = ~e;
      if ($urandom_range(0, 2999) == 0) l  = ~l;
      if ($urandom_range(0, 2999) == 0) rt = ~rt;
      if (!e && $urandom_range(0, 49) == 0) e = 1'b1;
      if (!l && $urandom_range(0, 49) == 0) l = 1'b1;
      applyStimulus(r, e, l, rt, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
